// File: rtl/seq_piso_serializer.sv
// MSB-first parallel-to-serial stage feeding a 1-bit sequence FSM input.
// Optional even-parity bit per frame when SEQ_PISO_SERIALIZER_PARITY_EN is defined.
module seq_piso_serializer #(
    parameter int unsigned nbits = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_val,
    output logic                          in_rdy,
    input  logic [nbits-1:0]              in_,
    output logic                          out,
    output logic                          out_val,
    output logic [$clog2(nbits+1)-1:0]    bit_idx
);

    localparam int unsigned IW = $clog2(nbits + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(nbits - 1);

`ifdef SEQ_PISO_SERIALIZER_PARITY_EN
    localparam logic [IW-1:0] PAR_IDX = IW'(nbits);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;
`else
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;
`endif

    state_e            state_q, state_d;
    logic [nbits-1:0]  shift_q, shift_d;
    logic              out_q, out_d;
    logic              out_val_q, out_val_d;
    logic [IW-1:0]     bit_idx_q, bit_idx_d;
`ifdef SEQ_PISO_SERIALIZER_PARITY_EN
    logic              par_q, par_d;
`endif

    logic last_data_c;
    logic final_c;
    logic xfer_c;

    // Ready on the cycle carrying the final frame bit, so the next word follows with no gap.
    always_comb begin
        last_data_c = (state_q == ST_SHIFT) && (bit_idx_q == LAST_IDX);
`ifdef SEQ_PISO_SERIALIZER_PARITY_EN
        final_c     = (state_q == ST_PARITY);
`else
        final_c     = last_data_c;
`endif
        in_rdy      = !reset && ((state_q == ST_IDLE) || final_c);
        xfer_c      = in_val && in_rdy;
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        out_d     = out_q;
        out_val_d = out_val_q;
        bit_idx_d = bit_idx_q;
`ifdef SEQ_PISO_SERIALIZER_PARITY_EN
        par_d     = par_q;
`endif

        if (xfer_c) begin
            // MSB goes straight to the output flop; the rest waits in the shifter.
            state_d   = ST_SHIFT;
            out_d     = in_[nbits-1];
            shift_d   = {in_[nbits-2:0], 1'b0};
            out_val_d = 1'b1;
            bit_idx_d = '0;
`ifdef SEQ_PISO_SERIALIZER_PARITY_EN
            par_d     = ^in_;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    out_d     = 1'b0;
                    out_val_d = 1'b0;
                    bit_idx_d = '0;
                end
                ST_SHIFT: begin
                    if (!last_data_c) begin
                        out_d     = shift_q[nbits-1];
                        shift_d   = {shift_q[nbits-2:0], 1'b0};
                        bit_idx_d = bit_idx_q + IW'(1);
                    end else begin
`ifdef SEQ_PISO_SERIALIZER_PARITY_EN
                        state_d   = ST_PARITY;
                        out_d     = par_q;
                        bit_idx_d = PAR_IDX;
`else
                        state_d   = ST_IDLE;
                        out_d     = 1'b0;
                        out_val_d = 1'b0;
                        bit_idx_d = '0;
`endif
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    out_d     = 1'b0;
                    out_val_d = 1'b0;
                    bit_idx_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            out_q     <= 1'b0;
            out_val_q <= 1'b0;
            bit_idx_q <= '0;
`ifdef SEQ_PISO_SERIALIZER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            out_q     <= out_d;
            out_val_q <= out_val_d;
            bit_idx_q <= bit_idx_d;
`ifdef SEQ_PISO_SERIALIZER_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign out     = out_q;
    assign out_val = out_val_q;
    assign bit_idx = bit_idx_q;

endmodule

// File: tb/tb_seq_piso_serializer.sv
// Directed bench for seq_piso_serializer (nbits=8); also covers the parity build
// when SEQ_PISO_SERIALIZER_PARITY_EN is defined.
module tb_seq_piso_serializer;

    localparam int unsigned NB = 8;
`ifdef SEQ_PISO_SERIALIZER_PARITY_EN
    localparam int unsigned FLEN = NB + 1;
`else
    localparam int unsigned FLEN = NB;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_val;
    logic          in_rdy;
    logic [NB-1:0] in_;
    logic          out;
    logic          out_val;
    logic [3:0]    bit_idx;

    int n_vec = 0;
    int n_err = 0;

    seq_piso_serializer #(.nbits(NB)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_     (in_),
        .out     (out),
        .out_val (out_val),
        .bit_idx (bit_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "/out"},     32'(out),     32'd0);
        chk({tag, "/out_val"}, 32'(out_val), 32'd0);
        chk({tag, "/bit_idx"}, 32'(bit_idx), 32'd0);
        chk({tag, "/in_rdy"},  32'(in_rdy),  32'd1);
    endtask

    // Checks one frame already transferred; at the final bit presents the next word.
    task automatic expect_frame(input logic [NB-1:0] w, input logic nxt_val,
                                input logic [NB-1:0] nxt, input logic noise);
        logic exp_bit;
        for (int k = 0; k < int'(FLEN); k++) begin
            exp_bit = (k < int'(NB)) ? w[NB-1-k] : ^w;
            chk("frame/out",     32'(out),     32'(exp_bit));
            chk("frame/out_val", 32'(out_val), 32'd1);
            chk("frame/bit_idx", 32'(bit_idx), 32'(k));
            chk("frame/in_rdy",  32'(in_rdy),  32'(k == int'(FLEN) - 1));
            if (k == int'(FLEN) - 1) begin
                in_val = nxt_val;
                in_    = nxt;
            end else if (noise) begin
                in_val = 1'b1;
                in_    = (k % 2 == 0) ? 8'hFF : 8'h00;
            end
            step();
        end
    endtask

    initial begin
        reset  = 1'b1;
        in_val = 1'b0;
        in_    = '0;
        step();
        chk("rst/out",     32'(out),     32'd0);
        chk("rst/out_val", 32'(out_val), 32'd0);
        chk("rst/in_rdy",  32'(in_rdy),  32'd0);
        step();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_idle("idle");
            step();
        end

        // Single word 0xA5
        in_val = 1'b1;
        in_    = 8'hA5;
        step();
        in_val = 1'b0;
        expect_frame(8'hA5, 1'b0, 8'h00, 1'b0);
        chk_idle("after_a5");

        // Back-to-back 0xF0, 0x0F
        in_val = 1'b1;
        in_    = 8'hF0;
        step();
        expect_frame(8'hF0, 1'b1, 8'h0F, 1'b0);
        expect_frame(8'h0F, 1'b0, 8'h00, 1'b0);
        chk_idle("after_b2b");

        // Reset mid-frame of 0xFF, then clean 0x81
        in_val = 1'b1;
        in_    = 8'hFF;
        step();
        in_val = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("pre_rst/bit_idx", 32'(bit_idx), 32'd3);
        chk("pre_rst/out",     32'(out),     32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst/out",     32'(out),     32'd0);
        chk("async_rst/out_val", 32'(out_val), 32'd0);
        chk("async_rst/bit_idx", 32'(bit_idx), 32'd0);
        chk("async_rst/in_rdy",  32'(in_rdy),  32'd0);
        step();
        reset = 1'b0;
        #1;
        chk_idle("post_rst");
        step();
        chk_idle("post_rst2");
        in_val = 1'b1;
        in_    = 8'h81;
        step();
        in_val = 1'b0;
        expect_frame(8'h81, 1'b0, 8'h00, 1'b0);
        chk_idle("after_81");

        // 0x3C with ignored in_val/in_ activity while not ready
        in_val = 1'b1;
        in_    = 8'h3C;
        step();
        in_val = 1'b0;
        expect_frame(8'h3C, 1'b0, 8'h00, 1'b1);
        chk_idle("after_3c");
        step();
        chk_idle("after_3c2");

`ifdef SEQ_PISO_SERIALIZER_PARITY_EN
        // Parity frames 0x07 (parity 1) then 0x03 (parity 0)
        in_val = 1'b1;
        in_    = 8'h07;
        step();
        expect_frame(8'h07, 1'b1, 8'h03, 1'b0);
        expect_frame(8'h03, 1'b0, 8'h00, 1'b0);
        chk_idle("after_par");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
